// File: rtl/mac_stream_feeder.sv
// rtl/mac_stream_feeder.sv - vector/mask stream source for the MAC array; define FEEDER_BACKTOBACK_EN for contiguous frames
module mac_stream_feeder #(
    parameter int J         = 14,
    parameter int I         = 7,
    parameter int A         = 2,
    parameter int DATAWIDTH = 32,
    localparam int J_WIDTH  = $clog2(J) + 1,
    localparam int M_AW     = $clog2(I * J) + 1,
    localparam int K_WIDTH  = $clog2(I) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 v_wr_en,
    input  logic [J_WIDTH-1:0]   v_wr_addr,
    input  logic [DATAWIDTH-1:0] v_wr_data,
    input  logic                 m_wr_en,
    input  logic [M_AW-1:0]      m_wr_addr,
    input  logic [A-1:0]         m_wr_data,
    input  logic                 start,
    input  logic                 beta_tvalid,
    output logic                 busy,
    output logic                 done,
    output logic [K_WIDTH-1:0]   frame_idx,
    output logic [DATAWIDTH-1:0] vinput,
    output logic                 vinput_tvalid,
    output logic                 vinput_tlast,
    output logic [A-1:0]         M_row,
    output logic                 M_row_tvalid,
    output logic                 M_row_tlast
);
    localparam int JI = $clog2(J);
    localparam int MI = $clog2(I * J);
    localparam int CW = $clog2(I + 1) + 1;
    localparam logic [JI-1:0]      J_LAST = JI'(J - 1);
    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(I - 1);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT_BETA, DRAIN, DONE} state_t;

    state_t               state, state_n;
    logic [JI-1:0]        j, emit_j;
    logic [K_WIDTH-1:0]   k, emit_k;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 emit, inc, dec, v_we, m_we;
    logic [DATAWIDTH-1:0] vbuf [J];
    logic [A-1:0]         mbuf [I*J];
    logic [MI-1:0]        m_rd_addr;
    logic [DATAWIDTH-1:0] v_rd;
    logic [A-1:0]         m_rd;

    assign v_we = v_wr_en && (state == IDLE) && (v_wr_addr < J_WIDTH'(J));
    assign m_we = m_wr_en && (state == IDLE) && (m_wr_addr < M_AW'(I * J));

    always_ff @(posedge clk) begin
        if (v_we) vbuf[v_wr_addr[JI-1:0]] <= v_wr_data;
        if (m_we) mbuf[m_wr_addr[MI-1:0]] <= m_wr_data;
    end

    // Bypass lets a write issued alongside start reach the very first beat.
    always_comb begin
        m_rd_addr = MI'(emit_k) * MI'(J) + MI'(emit_j);
        v_rd = (v_we && v_wr_addr[JI-1:0] == emit_j) ? v_wr_data : vbuf[emit_j];
        m_rd = (m_we && m_wr_addr[MI-1:0] == m_rd_addr) ? m_wr_data : mbuf[m_rd_addr];
    end

    assign inc = vinput_tvalid && vinput_tlast;
    assign dec = beta_tvalid && ((cnt != '0) || inc);

    always_comb begin
        cnt_n = cnt;
        if (inc && !dec)      cnt_n = cnt + CW'(1);
        else if (dec && !inc) cnt_n = cnt - CW'(1);
    end

    // emit/emit_j/emit_k describe the beat loaded into the output registers this edge.
    always_comb begin
        state_n = state;
        emit    = 1'b0;
        emit_j  = '0;
        emit_k  = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = STREAM;
                    emit    = 1'b1;
                    emit_k  = '0;
                end
            end
            STREAM: begin
                if (j != J_LAST) begin
                    emit   = 1'b1;
                    emit_j = j + JI'(1);
                end else if (k == K_LAST) begin
                    state_n = DRAIN;
                end else begin
`ifdef FEEDER_BACKTOBACK_EN
                    emit   = 1'b1;
                    emit_k = k + K_WIDTH'(1);
`else
                    state_n = WAIT_BETA;
`endif
                end
            end
            WAIT_BETA: begin
                if (beta_tvalid) begin
                    state_n = STREAM;
                    emit    = 1'b1;
                    emit_k  = k + K_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (cnt_n == '0) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                emit_k  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            j             <= '0;
            k             <= '0;
            cnt           <= '0;
            vinput        <= '0;
            vinput_tvalid <= 1'b0;
            vinput_tlast  <= 1'b0;
            M_row         <= '0;
        end else begin
            state         <= state_n;
            j             <= emit ? emit_j : j;
            k             <= emit_k;
            cnt           <= cnt_n;
            vinput        <= emit ? v_rd : '0;
            vinput_tvalid <= emit;
            vinput_tlast  <= emit && (emit_j == J_LAST);
            M_row         <= emit ? m_rd : '0;
        end
    end

    assign M_row_tvalid = vinput_tvalid;
    assign M_row_tlast  = vinput_tlast;
    assign busy         = (state == STREAM) || (state == WAIT_BETA) || (state == DRAIN);
    assign done         = (state == DONE);
    assign frame_idx    = k;
endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb/tb_mac_stream_feeder.sv - scoreboard bench for mac_stream_feeder
module tb_mac_stream_feeder;
    localparam int J   = 14;
    localparam int I   = 7;
    localparam int A   = 2;
    localparam int DW  = 32;
    localparam int JW  = $clog2(J) + 1;
    localparam int MAW = $clog2(I * J) + 1;
    localparam int FW  = $clog2(I) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_wr_en = 1'b0, m_wr_en = 1'b0, start = 1'b0, beta_tvalid = 1'b0;
    logic [JW-1:0]  v_wr_addr = '0;
    logic [DW-1:0]  v_wr_data = '0;
    logic [MAW-1:0] m_wr_addr = '0;
    logic [A-1:0]   m_wr_data = '0;
    logic busy, done, vinput_tvalid, vinput_tlast, M_row_tvalid, M_row_tlast;
    logic [FW-1:0]  frame_idx;
    logic [DW-1:0]  vinput;
    logic [A-1:0]   M_row;

    mac_stream_feeder #(.J(J), .I(I), .A(A), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .v_wr_en(v_wr_en), .v_wr_addr(v_wr_addr), .v_wr_data(v_wr_data),
        .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .start(start), .beta_tvalid(beta_tvalid),
        .busy(busy), .done(done), .frame_idx(frame_idx),
        .vinput(vinput), .vinput_tvalid(vinput_tvalid), .vinput_tlast(vinput_tlast),
        .M_row(M_row), .M_row_tvalid(M_row_tvalid), .M_row_tlast(M_row_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [A-1:0]  mrow;
        logic          last;
        logic [FW-1:0] fidx;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] v_mod [J];
    logic [A-1:0]  m_mod [I*J];
    int checks = 0;
    int errors = 0;
    int n;
    int nvalid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (vinput_tvalid === 1'b1) begin
            check("beat_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("vinput", vinput, e.data);
                check("m_row", M_row, e.mrow);
                check("tlast", vinput_tlast, e.last);
                check("m_row_tlast", M_row_tlast, e.last);
                check("m_row_tvalid", M_row_tvalid, 1);
                check("beat_frame_idx", frame_idx, e.fidx);
            end
        end
    end

    task automatic push_run();
        for (int kk = 0; kk < I; kk++)
            for (int jj = 0; jj < J; jj++)
                exp_q.push_back('{data: v_mod[jj], mrow: m_mod[kk*J+jj],
                                  last: (jj == J-1), fidx: FW'(kk)});
    endtask

    task automatic start_run();
        push_run();
        start = 1'b1;
        tick();
        start   = 1'b0;
        v_wr_en = 1'b0;
        check("busy_after_start", busy, 1);
        check("first_beat_valid", vinput_tvalid, 1);
    endtask

    task automatic wr_v(input int a, input logic [DW-1:0] d);
        v_wr_en = 1'b1; v_wr_addr = JW'(a); v_wr_data = d;
        tick();
        v_wr_en = 1'b0;
    endtask

    task automatic wr_m(input int a, input logic [A-1:0] d);
        m_wr_en = 1'b1; m_wr_addr = MAW'(a); m_wr_data = d;
        tick();
        m_wr_en = 1'b0;
    endtask

    task automatic wait_tlast();
        int w = 0;
        while (!(vinput_tvalid && vinput_tlast) && w < 60) begin
            tick();
            w++;
        end
        check("tlast_seen", 64'(w < 60), 1);
    endtask

    // Returns beta dly cycles after frame kk's tlast (dly >= 2); poke drives start and a write while waiting.
    task automatic pace(input int kk, input int dly, input bit poke);
        wait_tlast();
        check("tlast_frame_idx", frame_idx, kk);
        tick();
        check("gap_tvalid", vinput_tvalid, 0);
        check("gap_busy", busy, 1);
        if (poke) begin
            start = 1'b1; v_wr_en = 1'b1; v_wr_addr = JW'(3); v_wr_data = 32'hdead;
        end
        tick();
        start = 1'b0; v_wr_en = 1'b0;
        repeat (dly - 2) tick();
        beta_tvalid = 1'b1;
        tick();
        beta_tvalid = 1'b0;
        if (kk < I - 1) begin
            check("next_first_beat", vinput_tvalid, 1);
            check("next_frame_idx", frame_idx, kk + 1);
        end else begin
            check("done_pulse", done, 1);
            check("busy_low_at_done", busy, 0);
            check("done_frame_idx", frame_idx, I - 1);
            tick();
            check("done_one_cycle", done, 0);
            check("idle_frame_idx", frame_idx, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tvalid", vinput_tvalid, 0);
        check("rst_tlast", vinput_tlast, 0);
        check("rst_vinput", vinput, 0);
        check("rst_m_row", M_row, 0);
        check("rst_frame_idx", frame_idx, 0);
        rst = 1'b0;
        tick();

        for (int jj = 0; jj < J; jj++) begin
            v_mod[jj] = DW'(jj + 1);
            wr_v(jj, v_mod[jj]);
        end
        for (int mi = 0; mi < I*J; mi++) begin
            m_mod[mi] = A'(mi);
            wr_m(mi, m_mod[mi]);
        end

        wr_v(16, 32'h55);
        wr_m(98, 2'b00);
        wr_m(133, ~m_mod[5]);
        beta_tvalid = 1'b1;
        tick();
        beta_tvalid = 1'b0;
        check("idle_busy_after_beta", busy, 0);

`ifdef FEEDER_BACKTOBACK_EN
        start_run();
        nvalid = 0;
        for (int c = 0; c < I*J; c++) begin
            if (vinput_tvalid) nvalid++;
            if (c < I*J - 1) tick();
        end
        check("b2b_valid_beats", nvalid, I*J);
        tick();
        check("b2b_drain_tvalid", vinput_tvalid, 0);
        check("b2b_drain_busy", busy, 1);
        for (int b = 0; b < I; b++) begin
            repeat (3 + (b * 5) % 7) tick();
            beta_tvalid = 1'b1;
            tick();
            beta_tvalid = 1'b0;
            if (b < I - 1) check("b2b_not_done", done, 0);
            else           check("b2b_done", done, 1);
        end
        tick();
        check("b2b_idle_busy", busy, 0);
`else
        v_wr_en = 1'b1; v_wr_addr = '0; v_wr_data = 32'd100;
        v_mod[0] = 32'd100;
        start_run();
        for (int kk = 0; kk < I; kk++) pace(kk, 20, kk == 2);

        start_run();
        pace(0, 3, 1'b0);
        pace(1, 3, 1'b0);
        n = 0;
        while (!(vinput_tvalid && frame_idx == FW'(2) && vinput == v_mod[5]) && n < 40) begin
            tick();
            n++;
        end
        check("reach_f2_beat5", 64'(n < 40), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tvalid", vinput_tvalid, 0);
        check("midrst_vinput", vinput, 0);
        check("midrst_m_row", M_row, 0);
        check("midrst_tlast", vinput_tlast, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_idx", frame_idx, 0);
        exp_q.delete();
        tick();

        start_run();
        check("restart_frame_idx", frame_idx, 0);
        check("restart_vinput", vinput, v_mod[0]);
        for (int kk = 0; kk < I; kk++) pace(kk, 2, 1'b0);
`endif
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
